// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for pipeline stages: default field widths and the
// saturating Tnew decrement used whenever an entry advances or ages.
package pipe_stage_skid_pkg;

  localparam int TNEW_W_DEFAULT = 2;
  localparam int WA_W_DEFAULT   = 5;
  localparam int TNEW_MAX_W     = 8;

  // Callers zero-extend into TNEW_MAX_W bits and truncate the result back.
  function automatic logic [TNEW_MAX_W-1:0] sat_dec(input logic [TNEW_MAX_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid flag plus Tnew/we/wa/payload, with clear,
// load and in-place ageing controls (clear wins over load, load over age).
module pipe_entry_reg
  import pipe_stage_skid_pkg::*;
#(
  parameter int TNEW_W    = TNEW_W_DEFAULT,
  parameter int WA_W      = WA_W_DEFAULT,
  parameter int PAYLOAD_W = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 age,
  input  logic [TNEW_W-1:0]    d_tnew,
  input  logic                 d_we,
  input  logic [WA_W-1:0]      d_wa,
  input  logic [PAYLOAD_W-1:0] d_payload,
  output logic                 valid,
  output logic [TNEW_W-1:0]    tnew,
  output logic                 we,
  output logic [WA_W-1:0]      wa,
  output logic [PAYLOAD_W-1:0] payload
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid   <= 1'b0;
      tnew    <= '0;
      we      <= 1'b0;
      wa      <= '0;
      payload <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      tnew    <= d_tnew;
      we      <= d_we;
      wa      <= d_wa;
      payload <= d_payload;
    end else if (age && valid) begin
      tnew    <= TNEW_W'(sat_dec(TNEW_MAX_W'(tnew)));
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage carrying Tnew/we/wa for hazard detection.
// in_ready is registered so there is no combinational path from out_ready.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int PAYLOAD_W    = 128,
  parameter int TNEW_W       = TNEW_W_DEFAULT,
  parameter int WA_W         = WA_W_DEFAULT,
  parameter int AGE_ON_STALL = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TNEW_W-1:0]    in_tnew,
  input  logic                 in_we,
  input  logic [WA_W-1:0]      in_wa,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TNEW_W-1:0]    out_tnew,
  output logic                 out_we,
  output logic [WA_W-1:0]      out_wa,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occ
);

  logic                 head_v, skid_v;
  logic [TNEW_W-1:0]    head_tnew, skid_tnew, in_tnew_dec;
  logic                 head_we, skid_we;
  logic [WA_W-1:0]      head_wa, skid_wa;
  logic [PAYLOAD_W-1:0] head_payload, skid_payload;
  logic                 in_ready_r, accept, pop;
  logic                 head_load, head_clear, skid_load, skid_clear, age_en;

  assign accept      = in_valid & in_ready_r;
  assign pop         = head_v & out_ready;
  assign in_tnew_dec = TNEW_W'(sat_dec(TNEW_MAX_W'(in_tnew)));
  assign age_en      = (AGE_ON_STALL != 0) & ~pop;

  // Head takes the input when empty or replaced on pass-through; from skid when draining FULL.
  assign head_load  = ~flush & ((~head_v & accept) | (head_v & ~skid_v & accept & pop) | (skid_v & pop));
  assign head_clear = flush | (head_v & ~skid_v & pop & ~accept);
  assign skid_load  = ~flush & head_v & ~skid_v & accept & ~pop;
  assign skid_clear = flush | (skid_v & pop);

  always_ff @(posedge clk) begin
    if (reset || flush) in_ready_r <= 1'b1;
    else                in_ready_r <= ~((skid_v & ~pop) | skid_load);
  end

  pipe_entry_reg #(.TNEW_W(TNEW_W), .WA_W(WA_W), .PAYLOAD_W(PAYLOAD_W)) u_head (
    .clk       (clk),
    .reset     (reset),
    .clear     (head_clear),
    .load      (head_load),
    .age       (age_en),
    .d_tnew    (skid_v ? skid_tnew : in_tnew_dec),
    .d_we      (skid_v ? skid_we : in_we),
    .d_wa      (skid_v ? skid_wa : in_wa),
    .d_payload (skid_v ? skid_payload : in_payload),
    .valid     (head_v),
    .tnew      (head_tnew),
    .we        (head_we),
    .wa        (head_wa),
    .payload   (head_payload)
  );

  pipe_entry_reg #(.TNEW_W(TNEW_W), .WA_W(WA_W), .PAYLOAD_W(PAYLOAD_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (skid_clear),
    .load      (skid_load),
    .age       (age_en),
    .d_tnew    (in_tnew_dec),
    .d_we      (in_we),
    .d_wa      (in_wa),
    .d_payload (in_payload),
    .valid     (skid_v),
    .tnew      (skid_tnew),
    .we        (skid_we),
    .wa        (skid_wa),
    .payload   (skid_payload)
  );

  // Output stage: bubbles read as all-zero fields.
  assign in_ready    = in_ready_r;
  assign out_valid   = head_v;
  assign out_tnew    = head_v ? head_tnew : '0;
  assign out_we      = head_v & head_we;
  assign out_wa      = head_v ? head_wa : '0;
  assign out_payload = head_v ? head_payload : '0;
  assign occ         = {1'b0, head_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table plus randomized traffic
// against a queue model, run on one instance per AGE_ON_STALL setting.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_we, out_ready;
  logic [1:0]   in_tnew;
  logic [4:0]   in_wa;
  logic [127:0] in_payload;

  logic         irdy [2];
  logic         ov   [2];
  logic [1:0]   otn  [2];
  logic         owe  [2];
  logic [4:0]   owa  [2];
  logic [127:0] opl  [2];
  logic [1:0]   oocc [2];

  always #5 clk = ~clk;

  pipe_stage_skid #(.PAYLOAD_W(128), .TNEW_W(2), .WA_W(5), .AGE_ON_STALL(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irdy[0]),
    .in_tnew(in_tnew), .in_we(in_we), .in_wa(in_wa), .in_payload(in_payload),
    .out_valid(ov[0]), .out_ready(out_ready), .out_tnew(otn[0]), .out_we(owe[0]),
    .out_wa(owa[0]), .out_payload(opl[0]), .occ(oocc[0]));

  pipe_stage_skid #(.PAYLOAD_W(128), .TNEW_W(2), .WA_W(5), .AGE_ON_STALL(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irdy[1]),
    .in_tnew(in_tnew), .in_we(in_we), .in_wa(in_wa), .in_payload(in_payload),
    .out_valid(ov[1]), .out_ready(out_ready), .out_tnew(otn[1]), .out_we(owe[1]),
    .out_wa(owa[1]), .out_payload(opl[1]), .occ(oocc[1]));

  typedef struct {
    logic [1:0]   tnew;
    logic         we;
    logic [4:0]   wa;
    logic [127:0] pl;
  } ent_t;

  typedef struct {
    bit         rst, fl, iv;
    logic [1:0] it;
    logic [4:0] wa;
    bit         ordy;
    bit         ov;
    logic [1:0] t0, t1;
    logic [4:0] owa;
    logic [1:0] occ;
    bit         irdy;
  } vec_t;

  ent_t mq [2][$];
  bit   mrdy [2];
  int   total = 0;
  int   bad = 0;
  vec_t tbl [15];

  function automatic logic [1:0] dec2(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two entries; with ageing, every entry ages when nothing leaves.
  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      if (reset || flush) begin
        mq[k].delete();
        mrdy[k] = 1'b1;
      end else begin
        bit   p, a;
        ent_t e;
        p = (mq[k].size() > 0) && out_ready;
        a = in_valid && mrdy[k];
        if (p) void'(mq[k].pop_front());
        else if (k == 1) begin
          for (int i = 0; i < mq[k].size(); i++) begin
            e = mq[k][i];
            e.tnew = dec2(e.tnew);
            mq[k][i] = e;
          end
        end
        if (a) begin
          e.tnew = dec2(in_tnew);
          e.we   = in_we;
          e.wa   = in_wa;
          e.pl   = in_payload;
          mq[k].push_back(e);
        end
        mrdy[k] = (mq[k].size() < 2);
      end
    end
  endtask

  task automatic model_check();
    ent_t h;
    for (int k = 0; k < 2; k++) begin
      h = '{2'd0, 1'b0, 5'd0, 128'd0};
      if (mq[k].size() > 0) h = mq[k][0];
      chk($sformatf("m%0d.out_valid", k), 128'(ov[k]), 128'(mq[k].size() > 0));
      chk($sformatf("m%0d.out_tnew", k), 128'(otn[k]), 128'(h.tnew));
      chk($sformatf("m%0d.out_we", k), 128'(owe[k]), 128'(h.we));
      chk($sformatf("m%0d.out_wa", k), 128'(owa[k]), 128'(h.wa));
      chk($sformatf("m%0d.out_payload", k), opl[k], h.pl);
      chk($sformatf("m%0d.occ", k), 128'(oocc[k]), 128'(mq[k].size()));
      chk($sformatf("m%0d.in_ready", k), 128'(irdy[k]), 128'(mrdy[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    model_check();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_we = 1'b0; out_ready = 1'b0;
    in_tnew = 2'd0; in_wa = 5'd0; in_payload = '0;
    mrdy[0] = 1'b1; mrdy[1] = 1'b1;

    //            rst fl iv it wa ordy | ov t0 t1 owa occ irdy
    tbl[0]  = '{1, 0, 0, 2'd0, 5'd0,  0, 0, 2'd0, 2'd0, 5'd0,  2'd0, 1};
    tbl[1]  = '{0, 0, 1, 2'd2, 5'd5,  1, 1, 2'd1, 2'd1, 5'd5,  2'd1, 1};
    tbl[2]  = '{0, 0, 1, 2'd0, 5'd6,  1, 1, 2'd0, 2'd0, 5'd6,  2'd1, 1};
    tbl[3]  = '{0, 0, 1, 2'd3, 5'd7,  0, 1, 2'd0, 2'd0, 5'd6,  2'd2, 0};
    tbl[4]  = '{0, 0, 1, 2'd3, 5'd8,  0, 1, 2'd0, 2'd0, 5'd6,  2'd2, 0};
    tbl[5]  = '{0, 0, 0, 2'd0, 5'd0,  1, 1, 2'd2, 2'd1, 5'd7,  2'd1, 1};
    tbl[6]  = '{0, 0, 0, 2'd0, 5'd0,  0, 1, 2'd2, 2'd0, 5'd7,  2'd1, 1};
    tbl[7]  = '{0, 0, 1, 2'd1, 5'd9,  0, 1, 2'd2, 2'd0, 5'd7,  2'd2, 0};
    tbl[8]  = '{0, 1, 1, 2'd2, 5'd12, 1, 0, 2'd0, 2'd0, 5'd0,  2'd0, 1};
    tbl[9]  = '{0, 0, 1, 2'd3, 5'd10, 0, 1, 2'd2, 2'd2, 5'd10, 2'd1, 1};
    tbl[10] = '{0, 0, 0, 2'd0, 5'd0,  0, 1, 2'd2, 2'd1, 5'd10, 2'd1, 1};
    tbl[11] = '{0, 0, 0, 2'd0, 5'd0,  0, 1, 2'd2, 2'd0, 5'd10, 2'd1, 1};
    tbl[12] = '{0, 0, 0, 2'd0, 5'd0,  0, 1, 2'd2, 2'd0, 5'd10, 2'd1, 1};
    tbl[13] = '{0, 0, 1, 2'd1, 5'd11, 0, 1, 2'd2, 2'd0, 5'd10, 2'd2, 0};
    tbl[14] = '{1, 0, 1, 2'd3, 5'd3,  1, 0, 2'd0, 2'd0, 5'd0,  2'd0, 1};

    for (int i = 0; i < 15; i++) begin
      reset      = tbl[i].rst;
      flush      = tbl[i].fl;
      in_valid   = tbl[i].iv;
      in_tnew    = tbl[i].it;
      in_we      = 1'b1;
      in_wa      = tbl[i].wa;
      in_payload = {4{27'h5a5a5a5, tbl[i].wa}};
      out_ready  = tbl[i].ordy;
      step();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("v%0d.%0d.out_valid", i, k), 128'(ov[k]), 128'(tbl[i].ov));
        chk($sformatf("v%0d.%0d.out_we", i, k), 128'(owe[k]), 128'(tbl[i].ov));
        chk($sformatf("v%0d.%0d.out_tnew", i, k), 128'(otn[k]), 128'(k == 0 ? tbl[i].t0 : tbl[i].t1));
        chk($sformatf("v%0d.%0d.out_wa", i, k), 128'(owa[k]), 128'(tbl[i].owa));
        chk($sformatf("v%0d.%0d.occ", i, k), 128'(oocc[k]), 128'(tbl[i].occ));
        chk($sformatf("v%0d.%0d.in_ready", i, k), 128'(irdy[k]), 128'(tbl[i].irdy));
        if (!tbl[i].ov) chk($sformatf("v%0d.%0d.out_payload", i, k), opl[k], 128'd0);
      end
    end

    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 31) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_tnew    = 2'($urandom_range(0, 3));
      in_we      = 1'($urandom_range(0, 1));
      in_wa      = 5'($urandom_range(0, 31));
      in_payload = {$urandom(), $urandom(), $urandom(), $urandom()};
      out_ready  = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
